sar_seq_ctrl: RTL and testbench

- Parametrised successive-approximation sequencer; the next generation of the 4-bit big-FSM.
- Generalises to N_BITS and adds a configurable sample window and START/BUSY/DONE handshake.
- Adds an optional free-running continuous mode and a registered full-width result, including the LSB, instead of a transparent LSB pass-through.
- Sits between the comparator output and the per-bit small FSMs / capacitor-DAC switch drivers.

---
 rtl/sar_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl -- parametrised successive-approximation sequencer.
//
// Walks a SAR conversion: a sample window (SAR_RESET high), then one trial
// per bit from MSB to LSB (one-hot OUTEN), then a one-cycle FINISH where the
// full result, LSB included, appears on DOUT together with a DONE pulse.
//
// Parameters:
//   N_BITS        conversion resolution (2..12)
//   SAMPLE_CYCLES cycles SAR_RESET is held per conversion (1..15)
//   CONTINUOUS    1 = restart after FINISH without waiting for START
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous active-high reset
//   START      conversion request, looked at in IDLE and FINISH only
//   ABORT      (SAR_SEQ_ABORT_EN only) drop the conversion in SAMPLE/CONVERT
//   VCOMP      comparator decision for the bit currently enabled
//   OUTEN      one-hot trial enable, bit N_BITS-1 = MSB
//   SAR_RESET  high during the sample window
//   BUSY       high in SAMPLE and CONVERT
//   DONE       one-cycle pulse when DOUT is updated
//   DOUT       last completed result, held until the next DONE
//
// Optional feature: define SAR_SEQ_ABORT_EN to add the ABORT input.
//
// All outputs are registered from the next-state value, so nothing on the
// output side depends combinationally on VCOMP or START.

module sar_seq_ctrl #(
    parameter int N_BITS        = 4,
    parameter int SAMPLE_CYCLES = 1,
    parameter int CONTINUOUS    = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
`ifdef SAR_SEQ_ABORT_EN
    input  logic              ABORT,
`endif
    input  logic              VCOMP,
    output logic [N_BITS-1:0] OUTEN,
    output logic              SAR_RESET,
    output logic              BUSY,
    output logic              DONE,
    output logic [N_BITS-1:0] DOUT
);

    localparam int KW = $clog2(N_BITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [3:0]        scnt_q, scnt_d;
    logic [N_BITS-1:0] result_q, result_d;

    logic [N_BITS-1:0] outen_q;
    logic              sar_reset_q;
    logic              busy_q;
    logic              done_q;
    logic [N_BITS-1:0] dout_q;

    logic abort_w;
    logic restart_w;

`ifdef SAR_SEQ_ABORT_EN
    assign abort_w = ABORT;
`else
    assign abort_w = 1'b0;
`endif

    assign restart_w = START || (CONTINUOUS != 0);

    // Next-state, bit index, sample counter and result register.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        scnt_d   = scnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (restart_w) begin
                    state_d  = S_SAMPLE;
                    scnt_d   = '0;
                    result_d = '0;
                end
            end
            S_SAMPLE: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                end else if (scnt_q == 4'(SAMPLE_CYCLES - 1)) begin
                    state_d = S_CONVERT;
                    k_d     = KW'(N_BITS - 1);
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            S_CONVERT: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                end else begin
                    result_d[k_q] = VCOMP;
                    // k stops at 0 instead of wrapping; FINISH takes over.
                    if (k_q == '0) state_d = S_FINISH;
                    else           k_d     = k_q - KW'(1);
                end
            end
            S_FINISH: begin
                if (restart_w) begin
                    state_d  = S_SAMPLE;
                    scnt_d   = '0;
                    result_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            scnt_q      <= '0;
            result_q    <= '0;
            outen_q     <= '0;
            sar_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            scnt_q      <= scnt_d;
            result_q    <= result_d;
            outen_q     <= (state_d == S_CONVERT) ? (N_BITS'(1) << k_d) : '0;
            sar_reset_q <= (state_d == S_SAMPLE);
            busy_q      <= (state_d == S_SAMPLE) || (state_d == S_CONVERT);
            done_q      <= (state_d == S_FINISH);
            // FINISH is only entered from the LSB trial, so result_d already
            // holds the LSB decision and DOUT is valid alongside DONE.
            if (state_d == S_FINISH) dout_q <= result_d;
        end
    end

    assign OUTEN     = outen_q;
    assign SAR_RESET = sar_reset_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DOUT      = dout_q;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
module tb_sar_seq_ctrl;

    localparam int N  = 4;
    localparam int SA = 1;   // dut_a: single-shot, 1 sample cycle
    localparam int SC = 3;   // dut_c: continuous, 3 sample cycles

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic start_a = 1'b0, vcomp_a = 1'b0, abort_a = 1'b0;
    logic start_c = 1'b0, vcomp_c = 1'b1;
    logic [N-1:0] outen_a, dout_a, outen_c, dout_c;
    logic sr_a, busy_a, done_a, sr_c, busy_c, done_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    sar_seq_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(SA), .CONTINUOUS(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .START(start_a),
`ifdef SAR_SEQ_ABORT_EN
        .ABORT(abort_a),
`endif
        .VCOMP(vcomp_a), .OUTEN(outen_a), .SAR_RESET(sr_a),
        .BUSY(busy_a), .DONE(done_a), .DOUT(dout_a)
    );

    sar_seq_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(SC), .CONTINUOUS(1)) dut_c (
        .CLK(CLK), .RESET(RESET), .START(start_c),
`ifdef SAR_SEQ_ABORT_EN
        .ABORT(1'b0),
`endif
        .VCOMP(vcomp_c), .OUTEN(outen_c), .SAR_RESET(sr_c),
        .BUSY(busy_c), .DONE(done_c), .DOUT(dout_c)
    );

    // Reference model: t = cycles into the current conversion frame.
    // 0 = idle, 1..S = sample, S+1..S+N = bit trials MSB first, S+N+1 = finish.
    typedef struct {
        int         t;
        logic [N-1:0] res;
        logic [N-1:0] dout;
    } mdl_t;

    mdl_t m_a, m_c;

    function automatic mdl_t step(mdl_t m, int S, bit cont, bit st, bit vc, bit ab);
        mdl_t r = m;
        if (m.t == 0) begin
            if (st || cont) begin r.t = 1; r.res = '0; end
        end else if (m.t <= S + N) begin
            if (ab) r.t = 0;
            else if (m.t <= S) r.t = m.t + 1;
            else begin
                r.res[N-1-(m.t-S-1)] = vc;
                r.t = m.t + 1;
                if (r.t == S + N + 1) r.dout = r.res;
            end
        end else begin
            if (st || cont) begin r.t = 1; r.res = '0; end
            else r.t = 0;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_outen(mdl_t m, int S);
        logic [N-1:0] one = 1;
        if (m.t > S && m.t <= S + N) return one << (N - 1 - (m.t - S - 1));
        return '0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_dut(string p, mdl_t m, int S, logic [N-1:0] oe, logic sr,
                           logic bz, logic dn, logic [N-1:0] dout);
        chk({p, "_outen"}, 32'(oe), 32'(exp_outen(m, S)));
        chk({p, "_sar_reset"}, 32'(sr), 32'(m.t >= 1 && m.t <= S));
        chk({p, "_busy"}, 32'(bz), 32'(m.t >= 1 && m.t <= S + N));
        chk({p, "_done"}, 32'(dn), 32'(m.t == S + N + 1));
        chk({p, "_dout"}, 32'(dout), 32'(m.dout));
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET) begin
            m_a = '{0, '0, '0};
            m_c = '{0, '0, '0};
        end else begin
            m_a = step(m_a, SA, 1'b0, start_a, vcomp_a, abort_a);
            m_c = step(m_c, SC, 1'b1, start_c, vcomp_c, 1'b0);
        end
        cyc++;
        @(negedge CLK);
        chk_dut("a", m_a, SA, outen_a, sr_a, busy_a, done_a, dout_a);
        chk_dut("c", m_c, SC, outen_c, sr_c, busy_c, done_c, dout_c);
    endtask

    // Run dut_a to IDLE with START low, bounded.
    task automatic wait_idle_a();
        int n = 0;
        start_a = 1'b0;
        abort_a = 1'b0;
        while (m_a.t != 0 && n < 40) begin tick(); n++; end
        chk("wait_idle_bound", 32'(m_a.t), 32'd0);
    endtask

    // One START-initiated conversion on dut_a with a given VCOMP pattern;
    // returns the number of edges from the START edge to the DONE cycle.
    task automatic convert_a(input logic [N-1:0] pat, output int lat);
        lat = -1;
        start_a = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            start_a = 1'b0;
            if (m_a.t > SA && m_a.t <= SA + N) vcomp_a = pat[N-1-(m_a.t-SA-1)];
            if (done_a === 1'b1 && lat < 0) lat = i;
        end
    endtask

    initial begin
        int lat, ndone, last;
        m_a = '{0, '0, '0};
        m_c = '{0, '0, '0};

        // Reset state, then 10 idle cycles on dut_a.
        tick(); tick();
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Single conversion, pattern 1011, DONE 6 edges after START.
        convert_a(4'b1011, lat);
        chk("dir_done_latency", 32'(lat), 32'd6);
        chk("dir_dout_1011", 32'(dout_a), 32'h0000000b);

        // Continuous dut_c: DONE every 8 cycles with DOUT=1111.
        last = -1; ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_c === 1'b1) begin
                if (last >= 0) chk("cont_period", 32'(cyc - last), 32'd8);
                chk("cont_dout", 32'(dout_c), 32'h0000000f);
                last = cyc; ndone++;
            end
        end
        chk("cont_done_count_min", 32'(ndone >= 4), 32'd1);

        // Reset in the third bit trial: outputs drop at once, no DONE.
        wait_idle_a();
        start_a = 1'b1;
        for (int i = 0; i < 10 && m_a.t != SA + 3; i++) begin tick(); start_a = 1'b0; end
        chk("rst_reach_conv3", 32'(m_a.t), 32'(SA + 3));
        #2 RESET = 1'b1;
        #1;
        chk("rst_async_outen", 32'(outen_a), 32'd0);
        chk("rst_async_busy", 32'(busy_a), 32'd0);
        chk("rst_async_done", 32'(done_a), 32'd0);
        chk("rst_async_dout", 32'(dout_a), 32'd0);
        chk("rst_async_c_busy", 32'(busy_c), 32'd0);
        @(negedge CLK);
        tick();
        RESET = 1'b0;
        convert_a(4'b0101, lat);
        chk("rst_then_full_conv", 32'(lat), 32'd6);
        chk("rst_then_dout", 32'(dout_a), 32'h00000005);

        // START held high: back-to-back frames of S+N+1 = 6 cycles.
        wait_idle_a();
        start_a = 1'b1;
        ndone = 0;
        for (int i = 0; i < 18; i++) begin
            vcomp_a = 1'($urandom_range(0, 1));
            tick();
            if (done_a === 1'b1) ndone++;
        end
        chk("b2b_done_count", 32'(ndone), 32'd3);

        // START pulses while busy are not queued.
        wait_idle_a();
        start_a = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            start_a = (m_a.t >= 1 && m_a.t <= SA + N) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (done_a === 1'b1) ndone++;
        end
        chk("busy_start_ignored", 32'(ndone), 32'd1);

`ifdef SAR_SEQ_ABORT_EN
        // Abort in the second bit trial after a prior 0110 result.
        wait_idle_a();
        convert_a(4'b0110, lat);
        wait_idle_a();
        start_a = 1'b1;
        for (int i = 0; i < 10 && m_a.t != SA + 2; i++) begin tick(); start_a = 1'b0; end
        chk("abort_reach_conv2", 32'(m_a.t), 32'(SA + 2));
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_dout_held", 32'(dout_a), 32'h00000006);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (done_a === 1'b1) ndone++; end
        chk("abort_no_done", 32'(ndone), 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start_a = ($urandom_range(0, 3) == 0);
            vcomp_a = 1'($urandom_range(0, 1));
`ifdef SAR_SEQ_ABORT_EN
            abort_a = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
